// File: rtl/sin_rom_arbiter.sv
// Two-requester arbiter in front of a quarter-wave sine ROM: folds a phase into
// a quadrant address, waits out the ROM latency and returns a signed sample.
module sin_rom_arbiter #(
   parameter int PHASE_W     = 9,
   parameter int ADDR_W      = PHASE_W - 2,
   parameter int DATA_W      = 8,
   parameter int ROM_LATENCY = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   input  logic [PHASE_W-1:0] req0_phase,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [PHASE_W-1:0] req1_phase,
   output logic              req1_ready,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_dout,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_id,
   output logic [DATA_W:0]   rsp_data,
   output logic              busy
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] RESP = 2'd2;
   localparam int CNT_W = (ROM_LATENCY < 2) ? 1 : $clog2(ROM_LATENCY + 1);

   logic [1:0]         state;
   logic               last_grant;
   logic               grant;
   logic               neg;
   logic               id;
   logic [CNT_W-1:0]   cnt;
   logic [PHASE_W-1:0] sel_phase;
   logic               sel_valid;
   logic [ADDR_W-1:0]  fold_addr;
   logic [DATA_W:0]    magnitude;

   // A lone requester always wins; on a tie the one not served last goes first.
   always_comb begin
      grant = ~last_grant;
      if (req0_valid && !req1_valid) begin
         grant = 1'b0;
      end else if (req1_valid && !req0_valid) begin
         grant = 1'b1;
      end
   end

   assign req0_ready = ~rst & (state == IDLE) & ~grant;
   assign req1_ready = ~rst & (state == IDLE) & grant;
   assign busy       = (state != IDLE);

   assign sel_phase = grant ? req1_phase : req0_phase;
   assign sel_valid = grant ? req1_valid : req0_valid;
   // Odd quadrants run the table backwards; 127-p is just the bitwise inverse.
   assign fold_addr = sel_phase[PHASE_W-2] ? ~sel_phase[ADDR_W-1:0] : sel_phase[ADDR_W-1:0];
   assign magnitude = {1'b0, rom_dout};

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         rom_addr   <= '0;
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_data   <= '0;
         last_grant <= 1'b1;
         neg        <= 1'b0;
         id         <= 1'b0;
         cnt        <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (sel_valid) begin
                  rom_addr   <= fold_addr;
                  neg        <= sel_phase[PHASE_W-1];
                  id         <= grant;
                  last_grant <= grant;
                  cnt        <= CNT_W'(ROM_LATENCY);
                  state      <= WAIT;
               end
            end
            WAIT: begin
               if (cnt == '0) begin
                  rsp_data  <= neg ? -magnitude : magnitude;
                  rsp_id    <= id;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               rsp_valid <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sin_rom_arbiter.sv
// Bench for sin_rom_arbiter: a table of single transactions followed by
// directed sequences for arbitration, backpressure and mid-flight reset.
module tb_sin_rom_arbiter;

   logic       clk;
   logic       rst;
   logic       req0_valid;
   logic [8:0] req0_phase;
   logic       req0_ready;
   logic       req1_valid;
   logic [8:0] req1_phase;
   logic       req1_ready;
   logic [6:0] rom_addr;
   logic [7:0] rom_dout;
   logic       rsp_valid;
   logic       rsp_ready;
   logic       rsp_id;
   logic [8:0] rsp_data;
   logic       busy;
   logic       force255;

   int numChecks = 0;
   int numErrors = 0;

   typedef struct {
      logic       which;
      logic [8:0] phase;
      logic [6:0] expAddr;
      logic [8:0] expData;
      logic       rom255;
   } vec_t;

   vec_t vecs[8];

   sin_rom_arbiter dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_phase(req0_phase), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_phase(req1_phase), .req1_ready(req1_ready),
      .rom_addr(rom_addr), .rom_dout(rom_dout),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_data(rsp_data), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Registered ROM model: doubles the address, saturating at 255.
   always @(posedge clk) begin
      if (force255) rom_dout <= 8'hFF;
      else if ({1'b0, rom_addr, 1'b0} > 9'd255) rom_dout <= 8'hFF;
      else rom_dout <= {rom_addr, 1'b0};
   end

   initial begin
      #200000;
      $display("[TB] FAIL timeout: simulation did not reach the summary");
      $fatal(1, "[TB] timeout");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      numChecks++;
      if (actual !== expected) begin
         numErrors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic applyReset();
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // One isolated transaction, entered and left at a negedge in IDLE.
   task automatic applyStimulus(input vec_t v, input int idx);
      int waitCycles;
      string tag;
      tag = $sformatf("vec%0d", idx);
      force255 = v.rom255;
      rsp_ready = 1'b0;
      if (v.which) begin
         req1_valid = 1'b1;
         req1_phase = v.phase;
      end else begin
         req0_valid = 1'b1;
         req0_phase = v.phase;
      end
      #1;
      checkOutput({tag, " ready"}, {31'd0, v.which ? req1_ready : req0_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      checkOutput({tag, " rom_addr"}, {25'd0, rom_addr}, {25'd0, v.expAddr});
      checkOutput({tag, " busy"}, {31'd0, busy}, 32'd1);
      waitCycles = 0;
      while (!rsp_valid && waitCycles < 10) begin
         @(negedge clk);
         waitCycles++;
      end
      checkOutput({tag, " latency"}, waitCycles, 32'd2);
      checkOutput({tag, " rsp_data"}, {23'd0, rsp_data}, {23'd0, v.expData});
      checkOutput({tag, " rsp_id"}, {31'd0, rsp_id}, {31'd0, v.which});
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      checkOutput({tag, " busy after"}, {31'd0, busy}, 32'd0);
      checkOutput({tag, " rsp_valid after"}, {31'd0, rsp_valid}, 32'd0);
      force255 = 1'b0;
   endtask

   initial begin
      int waitCycles;
      int nGrant;
      int nResp;

      vecs[0] = '{1'b0, 9'd5,   7'd5,   9'd10,   1'b0};
      vecs[1] = '{1'b0, 9'd127, 7'd127, 9'd254,  1'b0};
      vecs[2] = '{1'b1, 9'd128, 7'd127, 9'd254,  1'b0};
      vecs[3] = '{1'b0, 9'd300, 7'd44,  9'h1A8,  1'b0};
      vecs[4] = '{1'b1, 9'd511, 7'd0,   9'h000,  1'b0};
      vecs[5] = '{1'b1, 9'd200, 7'd55,  9'd110,  1'b0};
      vecs[6] = '{1'b0, 9'd400, 7'd111, 9'h101,  1'b1};
      vecs[7] = '{1'b1, 9'd0,   7'd0,   9'd255,  1'b1};

      force255   = 1'b0;
      rsp_ready  = 1'b0;
      req0_phase = 9'd3;
      req1_phase = 9'd4;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      rst        = 1'b1;
      @(negedge clk);
      checkOutput("ready0 in reset", {31'd0, req0_ready}, 32'd0);
      checkOutput("ready1 in reset", {31'd0, req1_ready}, 32'd0);
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rst = 1'b0;
      #1;
      checkOutput("reset rom_addr", {25'd0, rom_addr}, 32'd0);
      checkOutput("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
      checkOutput("reset rsp_data", {23'd0, rsp_data}, 32'd0);
      checkOutput("reset rsp_id", {31'd0, rsp_id}, 32'd0);
      checkOutput("reset busy", {31'd0, busy}, 32'd0);

      for (int i = 0; i < 8; i++) applyStimulus(vecs[i], i);

      // Both requesters saturating: alternating grants, one accept per 4 cycles.
      applyReset();
      req0_phase = 9'd10;
      req1_phase = 9'd20;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      rsp_ready  = 1'b1;
      #1;
      nGrant = 0;
      nResp  = 0;
      for (int c = 0; c < 16; c++) begin
         if (req0_ready || req1_ready) begin
            checkOutput($sformatf("rr grant%0d who", nGrant), {31'd0, req1_ready}, nGrant % 2);
            checkOutput($sformatf("rr grant%0d cycle", nGrant), c, 4 * nGrant);
            nGrant++;
         end
         if (rsp_valid) begin
            checkOutput($sformatf("rr rsp%0d id", nResp), {31'd0, rsp_id}, nResp % 2);
            checkOutput($sformatf("rr rsp%0d data", nResp), {23'd0, rsp_data},
                        (nResp % 2) ? 32'd40 : 32'd20);
            checkOutput($sformatf("rr rsp%0d cycle", nResp), c, 4 * nResp + 3);
            nResp++;
         end
         @(negedge clk);
      end
      checkOutput("rr grant count", nGrant, 32'd4);
      checkOutput("rr rsp count", nResp, 32'd4);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rsp_ready  = 1'b0;
      applyReset();

      // Backpressure in RESP with both requesters knocking.
      req0_phase = 9'd300;
      req0_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req1_phase = 9'd20;
      req1_valid = 1'b1;
      waitCycles = 0;
      while (!rsp_valid && waitCycles < 10) begin
         checkOutput("bp ready0 in WAIT", {31'd0, req0_ready}, 32'd0);
         @(negedge clk);
         waitCycles++;
      end
      checkOutput("bp rsp_valid rose", {31'd0, rsp_valid}, 32'd1);
      for (int c = 0; c < 5; c++) begin
         checkOutput($sformatf("bp%0d rsp_valid", c), {31'd0, rsp_valid}, 32'd1);
         checkOutput($sformatf("bp%0d rsp_data", c), {23'd0, rsp_data}, 32'h1A8);
         checkOutput($sformatf("bp%0d rsp_id", c), {31'd0, rsp_id}, 32'd0);
         checkOutput($sformatf("bp%0d readies", c), {30'd0, req1_ready, req0_ready}, 32'd0);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready  = 1'b0;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      checkOutput("bp release busy", {31'd0, busy}, 32'd0);
      checkOutput("bp release rsp_valid", {31'd0, rsp_valid}, 32'd0);
      @(negedge clk);

      // Reset while waiting on the ROM after a req0 grant.
      req0_phase = 9'd5;
      req0_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req0_valid = 1'b0;
      checkOutput("rst-mid busy before", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("rst-mid rsp_valid", {31'd0, rsp_valid}, 32'd0);
      checkOutput("rst-mid busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      checkOutput("rst-mid rsp_valid later", {31'd0, rsp_valid}, 32'd0);
      req0_phase = 9'd7;
      req1_phase = 9'd9;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      checkOutput("rst-mid ready0", {31'd0, req0_ready}, 32'd1);
      checkOutput("rst-mid ready1", {31'd0, req1_ready}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      waitCycles = 0;
      while (!rsp_valid && waitCycles < 10) begin
         @(negedge clk);
         waitCycles++;
      end
      checkOutput("rst-mid post latency", waitCycles, 32'd2);
      checkOutput("rst-mid post id", {31'd0, rsp_id}, 32'd0);
      checkOutput("rst-mid post data", {23'd0, rsp_data}, 32'd14);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", numChecks, numErrors);
      $finish;
   end

endmodule
